// File: rtl/ttt_referee.sv
// Tic-tac-toe referee: owns the board, runs the human/AI turn handshake, validates moves, detects win/draw.
// Optional AI reply timeout with forfeit enabled by defining TTT_REF_AI_TIMEOUT_EN.
module ttt_referee #(
   parameter int AI_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        new_game,
   input  logic        human_valid,
   input  logic [1:0]  human_row,
   input  logic [1:0]  human_col,
   output logic        human_ready,
   output logic        ai_req,
   input  logic        ai_valid,
   input  logic [1:0]  ai_row,
   input  logic [1:0]  ai_col,
   output logic [17:0] board,
   output logic [3:0]  move_count,
   output logic        illegal,
   output logic        game_over,
   output logic [1:0]  winner
);

   // state    | meaning
   // WAIT_H   | waiting for a human move (human_ready high)
   // CHECK_H  | evaluate board after human move
   // REQ_AI   | requesting an AI move (ai_req high)
   // CHECK_AI | evaluate board after AI move
   // OVER     | game ended, board frozen
   typedef enum logic [2:0] {WAIT_H, CHECK_H, REQ_AI, CHECK_AI, OVER} state_t;

   localparam logic [17:0] BOARD_EMPTY = 18'h2AAAA;
   localparam logic [1:0]  CELL_HUMAN  = 2'd0;
   localparam logic [1:0]  CELL_AI     = 2'd1;
   localparam logic [1:0]  CELL_EMPTY  = 2'd2;

   state_t      state_q, state_d;
   logic [17:0] board_q, board_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  winner_q, winner_d;
   logic        illegal_q, illegal_d;
   logic        human_ready_q, ai_req_q, game_over_q;

`ifdef TTT_REF_AI_TIMEOUT_EN
   localparam int CW = (AI_TIMEOUT > 2) ? $clog2(AI_TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LOAD = CW'(AI_TIMEOUT - 1);
   logic [CW-1:0] tmo_q, tmo_d;
`endif

   function automatic logic has_line(input logic [17:0] b, input logic [1:0] v);
      logic [8:0] m;
      for (int i = 0; i < 9; i++) m[i] = (b[2*i +: 2] == v);
      return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
             (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
             (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
      return ({2'b00, r} * 4'd3) + {2'b00, c};
   endfunction

   function automatic logic is_legal(input logic [17:0] b, input logic [1:0] r, input logic [1:0] c);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 9; i++)
         if (4'(i) == cell_idx(r, c) && b[2*i +: 2] == CELL_EMPTY) ok = 1'b1;
      // row/col of 3 can alias a valid index, so bound them explicitly
      return ok && (r != 2'd3) && (c != 2'd3);
   endfunction

   function automatic logic [17:0] put(input logic [17:0] b, input logic [1:0] r, input logic [1:0] c,
                                       input logic [1:0] v);
      logic [17:0] nb;
      nb = b;
      for (int i = 0; i < 9; i++)
         if (4'(i) == cell_idx(r, c)) nb[2*i +: 2] = v;
      return nb;
   endfunction

   always_comb begin
      state_d   = state_q;
      board_d   = board_q;
      cnt_d     = cnt_q;
      winner_d  = winner_q;
      illegal_d = 1'b0;
`ifdef TTT_REF_AI_TIMEOUT_EN
      tmo_d     = tmo_q;
`endif
      if (new_game) begin
         state_d  = WAIT_H;
         board_d  = BOARD_EMPTY;
         cnt_d    = 4'd0;
         winner_d = CELL_EMPTY;
      end else begin
         case (state_q)
            WAIT_H: begin
               if (human_valid) begin
                  if (is_legal(board_q, human_row, human_col)) begin
                     board_d = put(board_q, human_row, human_col, CELL_HUMAN);
                     cnt_d   = (cnt_q < 4'd9) ? cnt_q + 4'd1 : cnt_q;
                     state_d = CHECK_H;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
            end
            CHECK_H: begin
               if (has_line(board_q, CELL_HUMAN)) begin
                  state_d  = OVER;
                  winner_d = CELL_HUMAN;
               end else if (cnt_q == 4'd9) begin
                  state_d  = OVER;
                  winner_d = CELL_EMPTY;
               end else begin
                  state_d = REQ_AI;
`ifdef TTT_REF_AI_TIMEOUT_EN
                  tmo_d   = TMO_LOAD;
`endif
               end
            end
            REQ_AI: begin
               if (ai_valid && is_legal(board_q, ai_row, ai_col)) begin
                  board_d = put(board_q, ai_row, ai_col, CELL_AI);
                  cnt_d   = (cnt_q < 4'd9) ? cnt_q + 4'd1 : cnt_q;
                  state_d = CHECK_AI;
               end else begin
                  illegal_d = ai_valid;
`ifdef TTT_REF_AI_TIMEOUT_EN
                  if (tmo_q == '0) begin
                     state_d  = OVER;
                     winner_d = CELL_HUMAN;
                  end else begin
                     tmo_d = tmo_q - 1'b1;
                  end
`endif
               end
            end
            CHECK_AI: begin
               if (has_line(board_q, CELL_AI)) begin
                  state_d  = OVER;
                  winner_d = CELL_AI;
               end else if (cnt_q == 4'd9) begin
                  state_d  = OVER;
                  winner_d = CELL_EMPTY;
               end else begin
                  state_d = WAIT_H;
               end
            end
            OVER:    state_d = OVER;
            default: state_d = WAIT_H;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= WAIT_H;
         board_q       <= BOARD_EMPTY;
         cnt_q         <= 4'd0;
         winner_q      <= CELL_EMPTY;
         illegal_q     <= 1'b0;
         human_ready_q <= 1'b1;
         ai_req_q      <= 1'b0;
         game_over_q   <= 1'b0;
`ifdef TTT_REF_AI_TIMEOUT_EN
         tmo_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         board_q       <= board_d;
         cnt_q         <= cnt_d;
         winner_q      <= winner_d;
         illegal_q     <= illegal_d;
         human_ready_q <= (state_d == WAIT_H);
         ai_req_q      <= (state_d == REQ_AI);
         game_over_q   <= (state_d == OVER);
`ifdef TTT_REF_AI_TIMEOUT_EN
         tmo_q         <= tmo_d;
`endif
      end
   end

   assign board       = board_q;
   assign move_count  = cnt_q;
   assign winner      = winner_q;
   assign illegal     = illegal_q;
   assign human_ready = human_ready_q;
   assign ai_req      = ai_req_q;
   assign game_over   = game_over_q;

endmodule

// File: tb/tb_ttt_referee.sv
// Self-checking bench for ttt_referee: turn-level game model compared every cycle, plus literal spot checks.
module tb_ttt_referee;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        new_game = 1'b0;
   logic        human_valid = 1'b0;
   logic [1:0]  human_row = 2'd0, human_col = 2'd0;
   logic        ai_valid = 1'b0;
   logic [1:0]  ai_row = 2'd0, ai_col = 2'd0;
   logic        human_ready, ai_req, illegal, game_over;
   logic [17:0] board;
   logic [3:0]  move_count;
   logic [1:0]  winner;

   int checks = 0;
   int errors = 0;
   bit done = 1'b0;

`ifdef TTT_REF_AI_TIMEOUT_EN
   localparam int AI_TO = 8;
`else
   localparam int AI_TO = 64;
`endif

   ttt_referee #(.AI_TIMEOUT(AI_TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .new_game   (new_game),
      .human_valid(human_valid),
      .human_row  (human_row),
      .human_col  (human_col),
      .human_ready(human_ready),
      .ai_req     (ai_req),
      .ai_valid   (ai_valid),
      .ai_row     (ai_row),
      .ai_col     (ai_col),
      .board      (board),
      .move_count (move_count),
      .illegal    (illegal),
      .game_over  (game_over),
      .winner     (winner)
   );

   always #5 clk = ~clk;

   // ---------------- game model ----------------
   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
   int cells [9];
   int m_moves, m_winner, waited;
   int turn;      // 0 human to move, 1 AI to move, -1 nobody (board being judged)
   int judging;   // player whose move is being judged, -1 if none
   bit m_over, m_ill;

   function automatic bit three_of(int who);
      for (int l = 0; l < 8; l++)
         if (cells[lines[l][0]] == who && cells[lines[l][1]] == who && cells[lines[l][2]] == who)
            return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit free_cell(int r, int c);
      return (r <= 2 && c <= 2 && cells[r*3 + c] == 2);
   endfunction

   task automatic clear_game();
      for (int i = 0; i < 9; i++) cells[i] = 2;
      m_moves = 0; m_winner = 2; m_over = 0; m_ill = 0;
      turn = 0; judging = -1; waited = 0;
   endtask

   task automatic model_step();
      if (!rst_n || new_game) begin
         clear_game();
         return;
      end
      m_ill = 0;
      if (m_over) return;
      if (judging != -1) begin
         if (three_of(judging)) begin
            m_over = 1; m_winner = judging;
         end else if (m_moves == 9) begin
            m_over = 1; m_winner = 2;
         end else begin
            turn = 1 - judging; waited = 0;
         end
         judging = -1;
      end else if (turn == 0) begin
         if (human_valid) begin
            if (free_cell(human_row, human_col)) begin
               cells[human_row*3 + human_col] = 0;
               m_moves++; judging = 0; turn = -1;
            end else m_ill = 1;
         end
      end else if (turn == 1) begin
         if (ai_valid && free_cell(ai_row, ai_col)) begin
            cells[ai_row*3 + ai_col] = 1;
            m_moves++; judging = 1; turn = -1;
         end else begin
            if (ai_valid) m_ill = 1;
`ifdef TTT_REF_AI_TIMEOUT_EN
            waited++;
            if (waited == AI_TO) begin
               m_over = 1; m_winner = 0; turn = -1;
            end
`endif
         end
      end
   endtask

   function automatic logic [17:0] model_board();
      logic [17:0] b;
      for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(cells[i]);
      return b;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      clear_game();
      forever begin
         @(posedge clk);
         model_step();
         #1;
         if (!done) begin
            chk("board",       int'(board),       int'(model_board()));
            chk("move_count",  int'(move_count),  m_moves);
            chk("human_ready", int'(human_ready), int'(!m_over && judging == -1 && turn == 0));
            chk("ai_req",      int'(ai_req),      int'(!m_over && judging == -1 && turn == 1));
            chk("illegal",     int'(illegal),     int'(m_ill));
            chk("game_over",   int'(game_over),   int'(m_over));
            chk("winner",      int'(winner),      m_winner);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic human(int r, int c);
      @(negedge clk);
      human_valid = 1'b1; human_row = 2'(r); human_col = 2'(c);
      @(negedge clk);
      human_valid = 1'b0;
   endtask

   task automatic ai(int r, int c);
      @(negedge clk);
      ai_valid = 1'b1; ai_row = 2'(r); ai_col = 2'(c);
      @(negedge clk);
      ai_valid = 1'b0;
   endtask

   task automatic pulse_new_game();
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!ai_req && n < 20) begin @(negedge clk); n++; end
      chk("ai_req_wait", int'(ai_req), 1);
   endtask

   task automatic wait_over();
      int n = 0;
      while (!game_over && n < 20) begin @(negedge clk); n++; end
      chk("game_over_wait", int'(game_over), 1);
   endtask

   task automatic round(int hr, int hc, int ar, int ac);
      human(hr, hc);
      wait_req();
      ai(ar, ac);
   endtask

   logic [17:0] snap;

   initial begin
      // reset
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_board",  int'(board), 'h2AAAA);
      chk("rst_ready",  int'(human_ready), 1);
      chk("rst_req",    int'(ai_req), 0);
      chk("rst_winner", int'(winner), 2);
      chk("rst_over",   int'(game_over), 0);

      // illegal human coordinate
      human(3, 0);
      chk("ill_h_pulse", int'(illegal), 1);
      chk("ill_h_board", int'(board), 'h2AAAA);

      // legal round with same-cycle AI reply
      human(1, 1);
      chk("h11_board", int'(board), 'h2A8AA);
      chk("h11_req_early", int'(ai_req), 0);
      @(negedge clk);
      chk("h11_req", int'(ai_req), 1);
      ai(0, 0);
      chk("a00_board", int'(board), 'h2A8A9);
      chk("a00_count", int'(move_count), 2);
      chk("a00_req_drop", int'(ai_req), 0);
      @(negedge clk);
      chk("a00_ready", int'(human_ready), 1);

      // stray AI move while waiting for the human is ignored
      ai(2, 0);
      chk("stray_ai", int'(board), 'h2A8A9);

      // illegal AI replay then retry
      human(0, 1);
      wait_req();
      ai(1, 1);
      chk("ill_ai_pulse", int'(illegal), 1);
      chk("ill_ai_req", int'(ai_req), 1);
      ai(2, 2);
      chk("retry_board", int'(board), 'h1A8A1);

      // back-to-back human_valid: only one accept
      @(negedge clk);
      human_valid = 1'b1; human_row = 2'd2; human_col = 2'd0;
      @(negedge clk); human_col = 2'd1;
      @(negedge clk); human_col = 2'd1;
      @(negedge clk); human_valid = 1'b0;
      chk("b2b_count", int'(move_count), 5);

      // new_game mid-handshake
      pulse_new_game();
      chk("ng_board", int'(board), 'h2AAAA);
      human(2, 2);
      wait_req();
      pulse_new_game();
      chk("ng_req_drop", int'(ai_req), 0);
      chk("ng_ready", int'(human_ready), 1);

      // human win on top row
      round(0, 0, 1, 0);
      round(0, 1, 1, 1);
      human(0, 2);
      wait_over();
      chk("hwin_winner", int'(winner), 0);
      snap = board;
      human(2, 2);
      chk("hwin_frozen", int'(board), int'(snap));
      pulse_new_game();

      // draw: X O X / X O O / O X X
      round(0, 0, 0, 1);
      round(0, 2, 1, 1);
      round(1, 0, 1, 2);
      round(2, 1, 2, 0);
      human(2, 2);
      wait_over();
      chk("draw_winner", int'(winner), 2);
      chk("draw_count", int'(move_count), 9);
      chk("draw_req", int'(ai_req), 0);
      pulse_new_game();
      chk("draw_ng_board", int'(board), 'h2AAAA);
      chk("draw_ng_ready", int'(human_ready), 1);
      chk("draw_ng_over", int'(game_over), 0);

`ifdef TTT_REF_AI_TIMEOUT_EN
      begin
         int n;
         human(1, 1);
         wait_req();
         snap = board;
         n = 0;
         while (!game_over && n < 20) begin @(negedge clk); n++; end
         chk("tmo_cycles", n, AI_TO);
         chk("tmo_winner", int'(winner), 0);
         chk("tmo_board", int'(board), int'(snap));
         pulse_new_game();
      end
`endif

      repeat (3) @(negedge clk);
      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ttt_referee.md
# ttt_referee

Game-control block that owns the tic-tac-toe board and sits opposite the AI move generator. It accepts human moves and requests AI moves with a req/valid handshake, then validates and applies each move. After every move it checks for a win or draw. It drives the 3x3 board (2 bits per cell) that feeds the AI and the display, and raises game-over with the winner.

## Interface
- `AI_TIMEOUT`, default 64: cycles allowed for an AI reply in `REQ_AI`. Used only with `TTT_REF_AI_TIMEOUT_EN`. Must be ≥ 2.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `new_game` in 1: one-cycle pulse; clears the game.
- `human_valid` in 1: a human move is presented.
- `human_row`, `human_col` in 2 each: human move coordinates.
- `human_ready` out 1: the referee is waiting for a human move.
- `ai_req` out 1: request for an AI move.
- `ai_valid` in 1: an AI move is presented.
- `ai_row`, `ai_col` in 2 each: AI move coordinates.
- `board` out 18: cell (r,c) is at bits [2*(3r+c)+1 : 2*(3r+c)]. Encoding: 0 = human, 1 = AI, 2 = empty.
- `move_count` out 4: number of moves applied, 0..9.
- `illegal` out 1: one-cycle pulse on a rejected move.
- `game_over` out 1: the game has ended.
- `winner` out 2: 0 = human, 1 = AI, 2 = draw or none.

## Operation
- **States:** `WAIT_H`, `CHECK_H`, `REQ_AI`, `CHECK_AI`, `OVER`. All outputs are registered.
- **Reset** (`rst_n`=0 at an edge):
  - every cell = 2; `move_count` = 0; state = `WAIT_H`
  - `human_ready` = 1; `ai_req` = 0; `illegal` = 0; `game_over` = 0; `winner` = 2
- **`WAIT_H`** (`human_ready` = 1): on `human_valid`, the move is legal when row ≤ 2, col ≤ 2 and the cell = 2.
  - Legal: write 0 to the cell, increment `move_count`, go to `CHECK_H`.
  - Illegal: pulse `illegal` and stay in `WAIT_H`.
- **`CHECK_H`**:
  - Any row, column or diagonal all 0 → `OVER`, `winner` = 0.
  - Otherwise `move_count` = 9 → `OVER`, `winner` = 2.
  - Otherwise → `REQ_AI`.
- **`REQ_AI`** (`ai_req` = 1): on `ai_valid`, the same legality rule applies.
  - Legal: write 1 to the cell, increment `move_count`, go to `CHECK_AI`.
  - Illegal: pulse `illegal`; `ai_req` stays high and the AI must retry.
- **`CHECK_AI`**:
  - Three 1s in a line → `OVER`, `winner` = 1.
  - Otherwise `move_count` = 9 → `OVER`, `winner` = 2.
  - Otherwise → `WAIT_H`.
- **`OVER`**: `game_over` = 1; the board is frozen and all moves are ignored.
- **Priority:** `rst_n` > `new_game` > moves.
  - `new_game` in any state clears the board, `move_count`, `winner` and `game_over`, then returns to `WAIT_H`.
  - `new_game` mid-handshake drops `ai_req` on the next edge.
- `human_valid` is ignored outside `WAIT_H`. `ai_valid` is ignored outside `REQ_AI`.
- `move_count` saturates at 9. It can reach 9 only on a human move (human moves first).

## Timing
- A human move sampled at edge N is visible on `board` and `move_count` after N. `human_ready` falls after N.
- `ai_req` rises after edge N+1 (`CHECK_H`).
- An AI move sampled at edge M:
  - `ai_req` falls and `board` updates after M
  - `human_ready` rises after M+1 (`CHECK_AI`)
- `game_over` and `winner` update together, one edge after the deciding move (the edge leaving `CHECK_*`).
- `illegal` is high for exactly one cycle, following the offending edge.
- `ai_valid` may arrive in the first cycle `ai_req` is visible.
- Back-to-back human moves: at most one accept per round. Extra `human_valid` cycles are ignored.

## Configuration
- `TTT_REF_AI_TIMEOUT_EN` defined:
  - A counter clears on entry to `REQ_AI` and counts each cycle there without a legal AI move.
  - On reaching `AI_TIMEOUT`, the AI forfeits: `OVER`, `winner` = 0, board unchanged.
  - Illegal AI moves do not reset the counter.
- Undefined: no counter; the referee waits in `REQ_AI` indefinitely.

## Test plan
- **Reset:** assert `rst_n`=0 for 2 cycles → `board` = 18'h2AAAA, `human_ready` = 1, `ai_req` = 0, `winner` = 2, `game_over` = 0.
- **Legal round:** human (1,1) → cell 4 = 0; `ai_req` two edges later. AI answers (0,0) the same cycle → cell 0 = 1, `move_count` = 2, `human_ready` back after one edge.
- **Illegal moves:**
  - Human (3,0) → `illegal` pulse, no board change.
  - AI replays a taken cell → `illegal` pulse, `ai_req` stays high; the AI retries (2,2) and it is accepted.
- **Human win:** human (0,0),(0,1),(0,2); AI (1,0),(1,1) → `game_over` = 1, `winner` = 0. A later `human_valid` is ignored.
- **Draw:** full 9-move sequence with no line → `winner` = 2 after the human's 9th move, `ai_req` never reasserted. Then `new_game` → cleared board, `WAIT_H`.
- **Timeout** (`TTT_REF_AI_TIMEOUT_EN`, `AI_TIMEOUT` = 8): no `ai_valid` → `winner` = 0, `game_over` = 1 exactly 8 cycles after `ai_req` rises.
